// File: rtl/utim64_pkg.sv
// Shared encodings for the utim64 compare channel: FSM states, mode values
// and the 32-bit byte-lane split used by the masked 64-bit registers.
package utim64_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DQM_LANE_W = 32;
    localparam int DQM_LANES  = 64 / DQM_LANE_W;

endpackage

// File: rtl/utim64_dqm_reg64.sv
// 64-bit register with two active-low lane write enables. Lanes not written
// by software take the alternate value when iALT_LOAD is set, otherwise hold.
module utim64_dqm_reg64
    import utim64_pkg::*;
#(
    parameter logic [63:0] P_INIT = 64'h0
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET,
    input  logic                 iWRITE,
    input  logic [DQM_LANES-1:0] inDQM,
    input  logic [63:0]          iWRITE_VALUE,
    input  logic                 iALT_LOAD,
    input  logic [63:0]          iALT_VALUE,
    output logic [63:0]          oVALUE
);

    logic [63:0] value;
    logic [63:0] valueNext;

    always_comb begin
        valueNext = value;
        for (int l = 0; l < DQM_LANES; l++) begin
            // A software write to a lane wins over the alternate load.
            if (iWRITE && !inDQM[l]) begin
                valueNext[l*DQM_LANE_W +: DQM_LANE_W] = iWRITE_VALUE[l*DQM_LANE_W +: DQM_LANE_W];
            end else if (iALT_LOAD) begin
                valueNext[l*DQM_LANE_W +: DQM_LANE_W] = iALT_VALUE[l*DQM_LANE_W +: DQM_LANE_W];
            end
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            value <= P_INIT;
        end else begin
            value <= valueNext;
        end
    end

    assign oVALUE = value;

endmodule

// File: rtl/utim64_comparator.sv
// utim64 compare channel: matches the main counter against a programmable
// compare value, raises a sticky IRQ, and optionally re-arms by a period.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | channel disarmed, counter value ignored
// ST_ARMED  | comparing every cycle while the main counter is working
module utim64_comparator
    import utim64_pkg::*;
#(
    parameter logic [63:0] P_COMP_INIT   = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [63:0] P_PERIOD_INIT = 64'h0
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iCONF_WRITE,
    input  logic        iCONF_ENA,
    input  logic        iCONF_MODE,
    input  logic        iCONF_IRQENA,
    input  logic        iCOMP_WRITE,
    input  logic [1:0]  inCOMP_DQM,
    input  logic [63:0] iCOMP_VALUE,
    input  logic        iPERIOD_WRITE,
    input  logic [1:0]  inPERIOD_DQM,
    input  logic [63:0] iPERIOD_VALUE,
    input  logic        iCOUNTER_WORKING,
    input  logic [63:0] iCOUNTER,
    input  logic        iIRQ_ACK,
    output logic        oIRQ_VALID,
    output logic        oPENDING,
    output logic        oOVERRUN,
    output logic        oARMED,
    output logic [63:0] oCOMP
);

    state_t      state;
    state_t      stateNext;
    logic        mode;
    logic        irqEna;
    logic        pending;
    logic        overrun;
    logic        match;
    logic        reload;
    logic [63:0] comp;
    logic [63:0] period;
    logic [63:0] compReload;

    assign match      = (state == ST_ARMED) && iCOUNTER_WORKING && (iCOUNTER == comp);
    // Reload uses the mode held before any conf write landing on this edge.
    assign reload     = match && (mode == MODE_PERIODIC);
    assign compReload = comp + period;

    always_comb begin
        stateNext = state;
        if (iCONF_WRITE) begin
            stateNext = iCONF_ENA ? ST_ARMED : ST_IDLE;
        end else if (match && (mode == MODE_ONESHOT)) begin
            stateNext = ST_IDLE;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state  <= ST_IDLE;
            mode   <= MODE_ONESHOT;
            irqEna <= 1'b0;
        end else begin
            state <= stateNext;
            if (iCONF_WRITE) begin
                mode   <= iCONF_MODE;
                irqEna <= iCONF_IRQENA;
            end
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
            if (pending) begin
                overrun <= !iIRQ_ACK;
            end
        end else if (iIRQ_ACK) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end
    end

    utim64_dqm_reg64 #(
        .P_INIT (P_COMP_INIT)
    ) uCompReg (
        .iCLOCK       (iCLOCK),
        .iRESET       (iRESET),
        .iWRITE       (iCOMP_WRITE),
        .inDQM        (inCOMP_DQM),
        .iWRITE_VALUE (iCOMP_VALUE),
        .iALT_LOAD    (reload),
        .iALT_VALUE   (compReload),
        .oVALUE       (comp)
    );

    utim64_dqm_reg64 #(
        .P_INIT (P_PERIOD_INIT)
    ) uPeriodReg (
        .iCLOCK       (iCLOCK),
        .iRESET       (iRESET),
        .iWRITE       (iPERIOD_WRITE),
        .inDQM        (inPERIOD_DQM),
        .iWRITE_VALUE (iPERIOD_VALUE),
        .iALT_LOAD    (1'b0),
        .iALT_VALUE   (64'h0),
        .oVALUE       (period)
    );

    assign oIRQ_VALID = pending && irqEna;
    assign oPENDING   = pending;
    assign oOVERRUN   = overrun;
    assign oARMED     = (state == ST_ARMED);
    assign oCOMP      = comp;

endmodule

// File: tb/tb_utim64_comparator.sv
// Bench for utim64_comparator: IRQ events go through an expected-event queue
// checked by a monitor; register/flag state is checked directly by stimulus.
module tb_utim64_comparator;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iCONF_WRITE, iCONF_ENA, iCONF_MODE, iCONF_IRQENA;
    logic        iCOMP_WRITE;
    logic [1:0]  inCOMP_DQM;
    logic [63:0] iCOMP_VALUE;
    logic        iPERIOD_WRITE;
    logic [1:0]  inPERIOD_DQM;
    logic [63:0] iPERIOD_VALUE;
    logic        iCOUNTER_WORKING;
    logic [63:0] iCOUNTER;
    logic        iIRQ_ACK;
    logic        oIRQ_VALID, oPENDING, oOVERRUN, oARMED;
    logic [63:0] oCOMP;

    typedef struct {
        logic [63:0] cnt;
        logic [63:0] comp;
    } irq_exp_t;

    irq_exp_t    sb[$];
    int          nCmp = 0;
    int          nErr = 0;
    bit          monEn = 0;
    bit          ackAuto = 0;
    logic [63:0] prevCnt = '0;

    utim64_comparator dut (
        .iCLOCK           (iCLOCK),
        .iRESET           (iRESET),
        .iCONF_WRITE      (iCONF_WRITE),
        .iCONF_ENA        (iCONF_ENA),
        .iCONF_MODE       (iCONF_MODE),
        .iCONF_IRQENA     (iCONF_IRQENA),
        .iCOMP_WRITE      (iCOMP_WRITE),
        .inCOMP_DQM       (inCOMP_DQM),
        .iCOMP_VALUE      (iCOMP_VALUE),
        .iPERIOD_WRITE    (iPERIOD_WRITE),
        .inPERIOD_DQM     (inPERIOD_DQM),
        .iPERIOD_VALUE    (iPERIOD_VALUE),
        .iCOUNTER_WORKING (iCOUNTER_WORKING),
        .iCOUNTER         (iCOUNTER),
        .iIRQ_ACK         (iIRQ_ACK),
        .oIRQ_VALID       (oIRQ_VALID),
        .oPENDING         (oPENDING),
        .oOVERRUN         (oOVERRUN),
        .oARMED           (oARMED),
        .oCOMP            (oCOMP)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the IRQ is presented, pop the expected event.
    initial begin
        forever begin
            @(negedge iCLOCK);
            if (monEn && oIRQ_VALID) begin
                if (sb.size() == 0) begin
                    chk("unexpected_irq_cnt", prevCnt, 64'hX);
                end else begin
                    irq_exp_t e;
                    e = sb.pop_front();
                    chk("irq_match_cnt", prevCnt, e.cnt);
                    chk("irq_comp", oCOMP, e.comp);
                end
            end
            prevCnt = iCOUNTER;
        end
    end

    task automatic tick();
        @(posedge iCLOCK);
        #1;
        iIRQ_ACK = ackAuto && oIRQ_VALID;
    endtask

    task automatic conf(input logic ena, input logic mode, input logic irq);
        iCONF_WRITE = 1'b1; iCONF_ENA = ena; iCONF_MODE = mode; iCONF_IRQENA = irq;
        tick();
        iCONF_WRITE = 1'b0;
    endtask

    task automatic writeComp(input logic [63:0] v, input logic [1:0] dqm);
        iCOMP_WRITE = 1'b1; iCOMP_VALUE = v; inCOMP_DQM = dqm;
        tick();
        iCOMP_WRITE = 1'b0;
    endtask

    task automatic writePeriod(input logic [63:0] v, input logic [1:0] dqm);
        iPERIOD_WRITE = 1'b1; iPERIOD_VALUE = v; inPERIOD_DQM = dqm;
        tick();
        iPERIOD_WRITE = 1'b0;
    endtask

    task automatic ackPulse();
        iIRQ_ACK = 1'b1;
        @(posedge iCLOCK);
        #1;
        iIRQ_ACK = 1'b0;
    endtask

    initial begin
        iRESET = 1'b1;
        iCONF_WRITE = 0; iCONF_ENA = 0; iCONF_MODE = 0; iCONF_IRQENA = 0;
        iCOMP_WRITE = 0; inCOMP_DQM = 2'b11; iCOMP_VALUE = '0;
        iPERIOD_WRITE = 0; inPERIOD_DQM = 2'b11; iPERIOD_VALUE = '0;
        iCOUNTER_WORKING = 0; iCOUNTER = '0; iIRQ_ACK = 0;
        #12;
        chk("rst_irq_valid", 64'(oIRQ_VALID), 64'd0);
        chk("rst_armed", 64'(oARMED), 64'd0);
        chk("rst_pending", 64'(oPENDING), 64'd0);
        chk("rst_comp", oCOMP, 64'hFFFF_FFFF_FFFF_FFFF);
        iRESET = 1'b0;
        tick();

        // One-shot at 100, then counter revisits 100 (as after a 2^64 wrap).
        writeComp(64'd100, 2'b00);
        conf(1'b1, 1'b0, 1'b1);
        sb.push_back('{cnt: 64'd100, comp: 64'd100});
        monEn = 1; ackAuto = 1;
        iCOUNTER_WORKING = 1;
        for (int c = 0; c <= 110; c++) begin
            iCOUNTER = 64'(c);
            if (c == 101) begin
                @(negedge iCLOCK);
                chk("oneshot_valid", 64'(oIRQ_VALID), 64'd1);
                chk("oneshot_disarm", 64'(oARMED), 64'd0);
            end
            tick();
        end
        for (int c = 95; c <= 105; c++) begin
            iCOUNTER = 64'(c);
            tick();
        end
        chk("oneshot_no_rematch", 64'(oPENDING), 64'd0);
        chk("oneshot_sb_empty", 64'(sb.size()), 64'd0);

        // Periodic 10, 15, 20 with acks.
        iCOUNTER_WORKING = 0;
        conf(1'b0, 1'b0, 1'b0);
        writeComp(64'd10, 2'b00);
        writePeriod(64'd5, 2'b00);
        conf(1'b1, 1'b1, 1'b1);
        sb.push_back('{cnt: 64'd10, comp: 64'd15});
        sb.push_back('{cnt: 64'd15, comp: 64'd20});
        sb.push_back('{cnt: 64'd20, comp: 64'd25});
        iCOUNTER_WORKING = 1;
        for (int c = 0; c <= 23; c++) begin
            iCOUNTER = 64'(c);
            tick();
        end
        iCOUNTER_WORKING = 0;
        tick();
        chk("periodic_comp25", oCOMP, 64'd25);
        chk("periodic_sb_empty", 64'(sb.size()), 64'd0);
        chk("periodic_armed", 64'(oARMED), 64'd1);
        monEn = 0; ackAuto = 0;
        tick();

        // Overrun with period 1, then ack coinciding with a match.
        conf(1'b0, 1'b0, 1'b0);
        writeComp(64'd50, 2'b00);
        writePeriod(64'd1, 2'b00);
        conf(1'b1, 1'b1, 1'b1);
        iCOUNTER_WORKING = 1;
        iCOUNTER = 64'd50; tick();
        iCOUNTER = 64'd51;
        @(negedge iCLOCK);
        chk("ovr_first_pending", 64'(oPENDING), 64'd1);
        chk("ovr_first_overrun", 64'(oOVERRUN), 64'd0);
        tick();
        iCOUNTER = 64'd52;
        @(negedge iCLOCK);
        chk("ovr_second_overrun", 64'(oOVERRUN), 64'd1);
        tick();
        iCOUNTER = 64'd53;
        ackPulse();
        iCOUNTER = 64'd54;
        @(negedge iCLOCK);
        chk("ackmatch_pending", 64'(oPENDING), 64'd1);
        chk("ackmatch_overrun", 64'(oOVERRUN), 64'd0);
        tick();
        iCOUNTER_WORKING = 0;
        ackPulse();
        chk("ack_clears_pending", 64'(oPENDING), 64'd0);
        chk("ack_clears_overrun", 64'(oOVERRUN), 64'd0);

        // Masked compare write colliding with a periodic reload.
        conf(1'b0, 1'b0, 1'b0);
        writeComp(64'h1_0000_0010, 2'b00);
        writePeriod(64'd8, 2'b00);
        conf(1'b1, 1'b1, 1'b0);
        iCOUNTER = 64'h1_0000_0010;
        iCOUNTER_WORKING = 1;
        iCOMP_WRITE = 1; iCOMP_VALUE = 64'hAAAA_0000_0000_0000; inCOMP_DQM = 2'b01;
        tick();
        iCOMP_WRITE = 0; iCOUNTER_WORKING = 0;
        chk("dqm_collision_comp", oCOMP, 64'hAAAA_0000_0000_0018);
        chk("dqm_pending", 64'(oPENDING), 64'd1);
        chk("dqm_irq_masked", 64'(oIRQ_VALID), 64'd0);
        ackPulse();

        // Wrap of the reload, irqena masking, counter-stopped gating.
        conf(1'b0, 1'b0, 1'b0);
        writeComp(64'hFFFF_FFFF_FFFF_FFFC, 2'b00);
        conf(1'b1, 1'b1, 1'b1);
        iCOUNTER = 64'hFFFF_FFFF_FFFF_FFFC;
        iCOUNTER_WORKING = 1;
        tick();
        iCOUNTER_WORKING = 0;
        chk("wrap_comp", oCOMP, 64'h4);
        chk("wrap_irq_valid", 64'(oIRQ_VALID), 64'd1);
        conf(1'b1, 1'b1, 1'b0);
        chk("irqena_masks_valid", 64'(oIRQ_VALID), 64'd0);
        chk("irqena_keeps_pending", 64'(oPENDING), 64'd1);
        ackPulse();
        iCOUNTER = 64'h4;
        for (int i = 0; i < 3; i++) tick();
        chk("stopped_no_pending", 64'(oPENDING), 64'd0);
        chk("stopped_still_armed", 64'(oARMED), 64'd1);

        // Async reset between edges while pending.
        conf(1'b1, 1'b1, 1'b1);
        iCOUNTER_WORKING = 1;
        tick();
        iCOUNTER_WORKING = 0;
        chk("pre_reset_valid", 64'(oIRQ_VALID), 64'd1);
        #2;
        iRESET = 1'b1;
        #1;
        chk("areset_pending", 64'(oPENDING), 64'd0);
        chk("areset_irq_valid", 64'(oIRQ_VALID), 64'd0);
        chk("areset_overrun", 64'(oOVERRUN), 64'd0);
        chk("areset_comp", oCOMP, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("areset_armed", 64'(oARMED), 64'd0);
        #1;
        iRESET = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/utim64_comparator.md
Name: utim64_comparator

Overview:
- Compare channel placed directly downstream of the utim64 64-bit main counter; it consumes the counter value and the working flag.
- Each cycle it checks the counter against a programmable 64-bit compare value and raises a sticky interrupt request on a match.
- One-shot mode disarms the channel after a match; periodic mode re-arms it by adding a programmable period to the compare value.
- Several instances sit in parallel under the utim64 register decoder.

Parameters:
- P_COMP_INIT, 64'hFFFF_FFFF_FFFF_FFFF, compare register value after reset.
- P_PERIOD_INIT, 64'h0, period register value after reset.

Ports:
- iCLOCK  in  1  system clock, rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iCONF_WRITE  in  1  config strobe.
- iCONF_ENA  in  1  arm (1) / disarm (0) the channel.
- iCONF_MODE  in  1  0 = one-shot, 1 = periodic.
- iCONF_IRQENA  in  1  IRQ output enable.
- iCOMP_WRITE  in  1  compare register write strobe.
- inCOMP_DQM  in  2  active-low byte-lane mask; [0] covers bits 31:0, [1] covers bits 63:32.
- iCOMP_VALUE  in  64  compare write data.
- iPERIOD_WRITE  in  1  period register write strobe.
- inPERIOD_DQM  in  2  active-low mask, same split as inCOMP_DQM.
- iPERIOD_VALUE  in  64  period write data.
- iCOUNTER_WORKING  in  1  main counter running flag.
- iCOUNTER  in  64  main counter value.
- iIRQ_ACK  in  1  single-cycle acknowledge pulse.
- oIRQ_VALID  out  1  equals pending AND irqena.
- oPENDING  out  1  sticky match flag.
- oOVERRUN  out  1  a match occurred while the flag was already pending.
- oARMED  out  1  FSM is in ARMED.
- oCOMP  out  64  current compare value.

Behaviour:
- Reset (async, iRESET=1):
  - FSM enters IDLE.
  - mode=0, irqena=0, pending=0, overrun=0.
  - comp=P_COMP_INIT, period=P_PERIOD_INIT.
  - All outputs follow these registers: oIRQ_VALID=0, oARMED=0, oCOMP=P_COMP_INIT.
- Reset asserted mid-operation discards pending and overrun immediately, without waiting for a clock edge.
- FSM states:
  - IDLE to ARMED on iCONF_WRITE with iCONF_ENA=1.
  - ARMED to IDLE on iCONF_WRITE with iCONF_ENA=0.
  - ARMED to IDLE on a match in one-shot mode.
- Config write latches mode and irqena on the same edge as the state change.
- match (combinational) = ARMED AND iCOUNTER_WORKING AND (iCOUNTER == comp), full 64-bit equality.
- Latency: a counter value equal to comp in cycle k sets pending after edge k, so oIRQ_VALID is high in cycle k+1.
- Periodic match: comp <= comp + period, modulo 2^64 (wraps, no saturation).
  - period=0 leaves comp unchanged; the next match comes after a full 2^64-cycle counter wrap.
  - period=1 matches on every cycle.
- One-shot match: comp is unchanged.
- Compare write, allowed in any state: each unmasked 32-bit half takes iCOMP_VALUE. Each masked half keeps its value, or takes the reloaded value if a periodic match occurs on the same edge.
- Period write uses the same DQM rule and is allowed in any state. A new period takes effect from the next match.
- Pending and overrun on each edge:
  - match and pending=0: pending <= 1.
  - match, pending=1, no ack: overrun <= 1.
  - ack, no match: pending <= 0, overrun <= 0.
  - ack and match on the same edge: pending stays 1, overrun <= 0.
  - ack while pending=0: no effect.
- Conf write on the same edge as a match:
  - The conf write decides the next FSM state.
  - The match still sets pending and still performs the periodic reload if mode was periodic before the write.
- Counter stopped (iCOUNTER_WORKING=0): no match, even when the values are equal. This prevents spurious IRQs while software loads the counter.
- Clearing irqena masks oIRQ_VALID but keeps pending.

Decomposition:
- Shared package utim64_pkg holds:
  - state encoding (ST_IDLE=1'b0, ST_ARMED=1'b1);
  - mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1);
  - DQM lane split constant (32).
- Sub-module utim64_dqm_reg64 is a 64-bit register with two active-low lane enables and a load-alternate input. It is instantiated twice, for comp and period.

Test Plan:
- One-shot:
  - Stimulus: comp=100, arm with mode=0, irqena=1; counter runs from 0.
  - Response: oIRQ_VALID rises in the cycle after iCOUNTER=100; oARMED=0 in the same cycle; no further IRQ at counter 2^64+100 after the counter is reloaded.
- Periodic:
  - Stimulus: comp=10, period=5, mode=1; ack each IRQ.
  - Response: IRQs follow counter values 10, 15, 20; oCOMP reads 25 after the third match.
- Overrun and simultaneous ack:
  - Stimulus: period=1, periodic mode, no ack.
  - Response: oOVERRUN=1 from the second match onward.
  - Stimulus: ack pulse coinciding with a match.
  - Response: oPENDING stays 1 and oOVERRUN=0.
- DQM write with reload collision:
  - Stimulus: comp=64'h1_00000010, period=8; write 64'hAAAA_0000_0000_0000 with inCOMP_DQM=2'b01 on the same edge as the match.
  - Response: comp=64'hAAAA_0000_0000_0018.
- Wrap and gating:
  - Stimulus: comp=64'hFFFF_FFFF_FFFF_FFFC, period=8, match.
  - Response: comp=64'h4.
  - Stimulus: iCOUNTER_WORKING=0 with iCOUNTER==comp.
  - Response: no pending.
- Async reset mid-pending:
  - Stimulus: pulse iRESET between clock edges while pending=1.
  - Response: oPENDING and oIRQ_VALID drop without waiting for a clock edge; oCOMP=P_COMP_INIT; oARMED=0.
